// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider / tick generator.
// Each channel produces a 50%-duty divided clock or a one-cycle tick at terminal count.
module clk_div_multi #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned CH_W         = 2,
    parameter int unsigned DEFAULT_DIV  = 25000,
    parameter int unsigned DEFAULT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [WIDTH-1:0] DefDiv  = WIDTH'(DEFAULT_DIV);
    localparam logic             DefMode = (DEFAULT_MODE != 0);

    logic [WIDTH-1:0]  div_q [NUM_CH];
    logic [WIDTH-1:0]  div_d [NUM_CH];
    logic [WIDTH-1:0]  cnt_q [NUM_CH];
    logic [WIDTH-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic              cfg_err_q, cfg_err_d;
    logic [NUM_CH-1:0] cfg_hit;
    logic [NUM_CH-1:0] term;

    // A divisor of zero is treated as one, so terminal count is then cnt == 0.
    always_comb begin
        cfg_hit = '0;
        term    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
            term[i]    = (div_q[i] == '0) ? (cnt_q[i] == '0)
                                          : (cnt_q[i] == div_q[i] - WIDTH'(1));
        end
    end

    always_comb begin
        cfg_err_d = cfg_we && (cfg_hit == '0);
        mode_d    = mode_q;
        clk_out_d = clk_out_q;
        tick_d    = tick_q;
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i] = div_q[i];
            cnt_d[i] = cnt_q[i];
            if (cfg_hit[i]) begin
                div_d[i]     = cfg_div;
                mode_d[i]    = cfg_mode;
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                tick_d[i]    = 1'b0;
            end else if (sync || !ch_en[i]) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                tick_d[i]    = 1'b0;
            end else if (term[i]) begin
                cnt_d[i]     = '0;
                tick_d[i]    = 1'b1;
                clk_out_d[i] = mode_q[i] ? ~clk_out_q[i] : 1'b0;
            end else begin
                cnt_d[i]  = cnt_q[i] + WIDTH'(1);
                tick_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DefDiv;
                cnt_q[i] <= '0;
            end
            mode_q    <= {NUM_CH{DefMode}};
            clk_out_q <= '0;
            tick_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (4 channels, 3-bit channel select).
module tb_clk_div_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CH_W   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [WIDTH-1:0]  cfg_div;
    logic              cfg_mode;
    logic              cfg_err;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .WIDTH       (WIDTH),
        .CH_W        (CH_W),
        .DEFAULT_DIV (25000),
        .DEFAULT_MODE(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ch_en   (ch_en),
        .sync    (sync),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_mode(cfg_mode),
        .cfg_err (cfg_err),
        .clk_out (clk_out),
        .tick    (tick)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] div,
                             input logic mode);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_div  = div;
        cfg_mode = mode;
        step();
        cfg_we   = 1'b0;
    endtask

    initial begin
        int acc, hi, tk, t2, t3, c3, tog;
        logic prev;

        rst = 1'b1; ch_en = 4'hF; sync = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;

        // Reset defaults: first tick 25000 cycles after release.
        step(); step();
        check_eq("rst_clk_out", 32'(clk_out), 32'h0);
        check_eq("rst_tick", 32'(tick), 32'h0);
        check_eq("rst_cfg_err", 32'(cfg_err), 32'h0);
        rst = 1'b0;
        acc = 0;
        repeat (24999) begin
            step();
            acc |= int'(tick) | int'(clk_out);
        end
        check_eq("default_pre_tick", 32'(acc), 32'h0);
        step();
        check_eq("default_tick", 32'(tick), 32'hF);
        check_eq("default_clk_out", 32'(clk_out), 32'hF);

        // Reprogram ch1 to div=5 toggle mode.
        cfg_write(3'd1, 16'd5, 1'b1);
        check_eq("reprog_clk_out", 32'(clk_out), 32'hD);
        check_eq("reprog_tick", 32'(tick), 32'h0);
        check_eq("reprog_cfg_err", 32'(cfg_err), 32'h0);
        acc = 0;
        repeat (4) begin
            step();
            acc |= int'(tick[1]);
        end
        check_eq("reprog_pre_tick", 32'(acc), 32'h0);
        step();
        check_eq("reprog_first_tick", 32'(tick[1]), 32'h1);
        check_eq("reprog_clk_rise", 32'(clk_out), 32'hF);
        hi = 0; tk = 0;
        repeat (10) begin
            step();
            hi += int'(clk_out[1]);
            tk += int'(tick[1]);
        end
        check_eq("reprog_high_phase", 32'(hi), 32'd5);
        check_eq("reprog_tick_count", 32'(tk), 32'd2);
        check_eq("reprog_others", 32'({clk_out[3:2], clk_out[0]}), 32'h7);

        // Edge divisors: div=1 toggle on ch2, div=0 tick-only on ch3 (index 3 valid).
        cfg_write(3'd2, 16'd1, 1'b1);
        cfg_write(3'd3, 16'd0, 1'b0);
        check_eq("ch3_write_no_err", 32'(cfg_err), 32'h0);
        t2 = 0; t3 = 0; c3 = 0; tog = 0;
        prev = clk_out[2];
        repeat (6) begin
            step();
            t2  += int'(tick[2]);
            t3  += int'(tick[3]);
            c3  += int'(clk_out[3]);
            tog += int'(clk_out[2] != prev);
            prev = clk_out[2];
        end
        check_eq("div1_tick_const", 32'(t2), 32'd6);
        check_eq("div1_clk_toggles", 32'(tog), 32'd6);
        check_eq("div0_tick_const", 32'(t3), 32'd6);
        check_eq("div0_clk_stuck", 32'(c3), 32'd0);

        // Invalid channel write: error pulse only, ch1 keeps its period of 5.
        cfg_we = 1'b1; cfg_ch = 3'd5; cfg_div = 16'd2; cfg_mode = 1'b0;
        step();
        cfg_we = 1'b0;
        check_eq("inv_err_pulse", 32'(cfg_err), 32'h1);
        step();
        check_eq("inv_err_clear", 32'(cfg_err), 32'h0);
        tk = 0;
        repeat (10) begin
            step();
            tk += int'(tick[1]);
        end
        check_eq("inv_ch1_period", 32'(tk), 32'd2);
        check_eq("inv_ch23_tick", 32'(tick[3:2]), 32'h3);
        check_eq("inv_ch0_clk", 32'(clk_out[0]), 32'h1);

        // Sync: ch0 div=7, ch1 div=3 restart together.
        cfg_write(3'd0, 16'd7, 1'b1);
        cfg_write(3'd1, 16'd3, 1'b1);
        repeat (8) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_eq("sync_clk_out", 32'(clk_out), 32'h0);
        check_eq("sync_tick", 32'(tick), 32'h0);
        for (int k = 1; k <= 7; k++) begin
            step();
            check_eq($sformatf("sync_tick0_k%0d", k), 32'(tick[0]), 32'(k == 7));
            check_eq($sformatf("sync_tick1_k%0d", k), 32'(tick[1]), 32'(k % 3 == 0));
        end
        check_eq("sync_clk0_rise", 32'(clk_out[0]), 32'h1);

        // Disable ch0 for 4 cycles, then first tick 7 cycles after re-enable.
        ch_en = 4'b1110;
        acc = 0;
        repeat (4) begin
            step();
            acc |= int'(clk_out[0]) | int'(tick[0]);
        end
        check_eq("dis_ch0_quiet", 32'(acc), 32'h0);
        ch_en = 4'hF;
        acc = 0;
        repeat (6) begin
            step();
            acc |= int'(tick[0]);
        end
        check_eq("reen_pre_tick", 32'(acc), 32'h0);
        step();
        check_eq("reen_first_tick", 32'(tick[0]), 32'h1);

        // Priority: rst beats a simultaneous cfg write and sync.
        rst = 1'b1; sync = 1'b1;
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd4; cfg_mode = 1'b1;
        step();
        rst = 1'b0; sync = 1'b0; cfg_we = 1'b0;
        check_eq("prio_rst_clk_out", 32'(clk_out), 32'h0);
        check_eq("prio_rst_tick", 32'(tick), 32'h0);
        check_eq("prio_rst_cfg_err", 32'(cfg_err), 32'h0);
        acc = 0;
        repeat (20) begin
            step();
            acc |= int'(tick);
        end
        check_eq("prio_rst_default_div", 32'(acc), 32'h0);

        // Without rst: the write lands and sync restarts every channel.
        sync = 1'b1;
        cfg_write(3'd0, 16'd4, 1'b1);
        sync = 1'b0;
        check_eq("prio_sync_clk_out", 32'(clk_out), 32'h0);
        check_eq("prio_sync_tick", 32'(tick), 32'h0);
        acc = 0;
        repeat (3) begin
            step();
            acc |= int'(tick);
        end
        check_eq("prio_sync_pre_tick", 32'(acc), 32'h0);
        step();
        check_eq("prio_sync_div4_tick", 32'(tick), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Multi-channel, runtime-programmable clock divider and tick generator. It is the parametrised successor of the fixed single-output display divider. Each channel derives either a 50%-duty divided clock or a one-cycle tick strobe from the system clock. A small configuration write port reprograms any channel's divisor and mode at run time, and a global sync pulse phase-aligns all channels. Consumers are display scan, debounce sampling and protocol timing in the authentication datapath.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
WIDTH, 16, divisor/counter width in bits
CH_W, 2, width of channel-select field; NUM_CH <= 2**CH_W
DEFAULT_DIV, 25000, per-channel divisor loaded at reset; must fit in WIDTH
DEFAULT_MODE, 1, per-channel mode at reset (1 = toggle/clock, 0 = tick only)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
ch_en  in  NUM_CH  per-channel run enable, level-sensitive
sync  in  1  one-cycle pulse; restarts all channels at phase 0
cfg_we  in  1  configuration write strobe, one cycle per write
cfg_ch  in  CH_W  target channel of the write
cfg_div  in  WIDTH  new divisor for the target channel
cfg_mode  in  1  new mode for the target channel (1 toggle, 0 tick)
cfg_err  out  1  registered one-cycle pulse: write to a channel index >= NUM_CH
clk_out  out  NUM_CH  divided clock per channel (registered)
tick  out  NUM_CH  one-cycle strobe per channel at each terminal count (registered)

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst sampled high on a rising clk edge applies reset on that edge.
- Per-channel state: div_r[WIDTH], mode_r, cnt[WIDTH].
- Reset values:
  - div_r = DEFAULT_DIV, mode_r = DEFAULT_MODE, cnt = 0 on every channel.
  - clk_out = 0, tick = 0, cfg_err = 0.
- Effective divisor: eff = (div_r == 0) ? 1 : div_r. A divisor of 0 behaves exactly as 1.
- Counting, per channel, when ch_en[i]=1 and no higher-priority event:
  - If cnt == eff-1, terminal count is reached: cnt <= 0 and tick[i] <= 1. If mode_r=1, clk_out[i] <= ~clk_out[i]; if mode_r=0, clk_out[i] holds 0.
  - Otherwise cnt <= cnt+1 and tick[i] <= 0.
- Timing that follows from these rules:
  - tick period = eff cycles, high for 1 cycle. With eff=1, tick stays high continuously.
  - Toggle-mode clk_out period = 2*eff cycles at 50% duty. With eff=1, clk_out = clk/2.
  - First tick after a restart from cnt=0 asserts eff cycles after the restart edge.
- Disable: when ch_en[i]=0, cnt <= 0, clk_out[i] <= 0 and tick[i] <= 0. On re-enable, counting restarts from phase 0.
- Config write, when cfg_we=1 and cfg_ch < NUM_CH, takes effect on that edge for the target channel:
  - div_r <= cfg_div, mode_r <= cfg_mode.
  - cnt <= 0, clk_out <= 0, tick <= 0.
  - Counting under the new settings begins on the next cycle.
  - The write lands even when the channel is disabled. Other channels are unaffected.
- Invalid write, when cfg_we=1 and cfg_ch >= NUM_CH:
  - No state changes.
  - cfg_err <= 1 for exactly one cycle; otherwise cfg_err <= 0.
- Sync: when sync=1, every channel sets cnt <= 0, clk_out <= 0, tick <= 0 on that edge. Divisors and modes are kept.
- Priority, per channel: rst > cfg write to this channel > sync > ch_en=0 > normal counting.
  - A cfg write and sync in the same cycle both clear; the target channel additionally takes the new div/mode.
- A mode change from toggle to tick via cfg forces clk_out to 0 immediately. clk_out never glitches; it changes only on clk edges.
- Reset applied mid-count restores all reset values on that edge regardless of other inputs.
- Counter arithmetic is unsigned in WIDTH bits. cnt never exceeds eff-1, so no wrap-around is reachable.

Test Plan:
- Reset defaults: hold rst 2 cycles, ch_en=4'hF. Required: clk_out=0 and tick=0 during reset; first tick on every channel 25000 cycles after rst falls; clk_out toggles every 25000 cycles (period 50000).
- Reprogram: write ch1 div=5 mode=1. Required: ch1 clk_out=0 on the write edge; tick[1] every 5 cycles; clk_out[1] period 10 with high and low phases of 5; ch0/2/3 phases undisturbed.
- Edge divisors: ch2 div=1 mode=1 gives tick[2] constant 1 and clk_out[2] toggling every cycle. ch3 div=0 mode=0 gives identical ticks and clk_out[3] stuck at 0.
- Invalid write: NUM_CH=4, cfg_ch=3 is valid; set CH_W=3 and cfg_ch=5. Required: cfg_err high exactly 1 cycle; no channel state changes.
- Sync/enable: run ch0 div=7 and ch1 div=3, pulse sync at an arbitrary cycle. Required: both clk_out=0 and cnt=0 after the edge; first ticks 7 and 3 cycles later. Drop ch_en[0] for 4 cycles: clk_out[0] low, tick[0] silent, then the first tick 7 cycles after re-enable.
- Priority: assert cfg_we (ch0 div=4), sync and rst together. Required: reset values, so div_r returns to DEFAULT_DIV. Repeat without rst: ch0 div=4 applied and all channels phase 0.
